// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: start/busy/done handshake plus data.
// Optional SERIAL_SUB_OVF_EN adds the signed-overflow flag.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor computing a - b LSB-first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] ra_r;
  logic [WIDTH-1:0] rb_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             done_r;
  logic             d_s;
  logic             bo_s;
  logic             last_s;

  // One full-subtractor step: {borrow_out, difference}
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
    logic dd;
    logic bo;
    dd = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
    return {bo, dd};
  endfunction

  // Current subtract step and last-step detection
  always_comb begin
    d_s    = 1'b0;
    bo_s   = 1'b0;
    last_s = 1'b0;
    {bo_s, d_s} = full_sub(ra_r[0], rb_r[0], borrow_r);
    if (count_r == CW'(WIDTH - 1)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      ra_r     <= {WIDTH{1'b0}};
      rb_r     <= {WIDTH{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      count_r  <= {CW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            ra_r     <= bus.a;
            rb_r     <= bus.b;
            borrow_r <= 1'b0;
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= ST_SHIFT;
          end else begin
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          ra_r     <= ra_r >> 1;
          rb_r     <= rb_r >> 1;
          diff_r   <= {d_s, diff_r[WIDTH-1:1]};
          borrow_r <= bo_s;
          count_r  <= count_r + CW'(1);
          if (last_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.diff   = diff_r;
  assign bus.borrow = borrow_r;

`ifdef SERIAL_SUB_OVF_EN
  logic amsb_r;
  logic bmsb_r;
  logic ovf_r;

  // Original operand sign bits and overflow flag registered on the final step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amsb_r <= 1'b0;
      bmsb_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if ((state_r == ST_IDLE) && bus.start) begin
      amsb_r <= bus.a[WIDTH-1];
      bmsb_r <= bus.b[WIDTH-1];
    end else if ((state_r == ST_SHIFT) && last_s) begin
      ovf_r  <= (amsb_r != bmsb_r) && (d_s != amsb_r);
    end else begin
      ovf_r  <= ovf_r;
    end
  end

  assign bus.ovf = ovf_r;
`endif
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor. It computes `a - b` LSB-first, one full-subtractor step per clock, using a single borrow flip-flop. It is the subtract-direction counterpart to the team's full-adder arithmetic blocks, for area-constrained datapaths where the result can take WIDTH cycles. Operands are loaded with a start/busy/done handshake; the result is held until the next accepted start.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `a` input WIDTH: minuend; captured on accepted start.
- `b` input WIDTH: subtrahend; captured on accepted start.
- `busy` output 1: high while subtraction is in progress.
- `done` output 1: one-cycle pulse; result valid.
- `diff` output WIDTH: `a - b` modulo 2^WIDTH; valid from `done` until the next accepted start.
- `borrow` output 1: final borrow-out; 1 iff unsigned `a < b`.
- `ovf` output 1: signed overflow flag; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE:**
  - If `start`=1, latch `a`→`ra` and `b`→`rb`, clear the borrow flop, set count=0, and go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT, each cycle:**
  - With `x=ra[0]`, `y=rb[0]`, `bi=borrow flop`:
    - `d = x^y^bi`
    - `bo = (~x&y) | (~(x^y)&bi)`
  - `ra` and `rb` shift right by 1.
  - `d` shifts into the diff register MSB; the diff register shifts right.
  - The borrow flop takes `bo`, and count increments.
  - When count reaches WIDTH-1, this step is the last; go to DONE.
- **DONE:**
  - `done`=1 for exactly one cycle, then go to IDLE.
  - `diff` holds the full result with bit i = step i.
  - `borrow` = final `bo`.
- `start` asserted in SHIFT or DONE is ignored and is not queued. The operands of an ignored start are dropped.
- Input `a`/`b` changes after capture have no effect on the result.
- `diff`/`borrow` contents during SHIFT are intermediate and not valid. After DONE they hold until the next accepted start.
- Arithmetic is modulo 2^WIDTH. `diff` equals `(a + ~b + 1) mod 2^WIDTH` for all inputs.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0.
  - Count and operand registers are cleared.
- Reset asserted mid-SHIFT aborts the operation immediately. No `done` is produced. Outputs take their reset values.
- `start` sampled high in IDLE at edge E:
  - `busy`=1 after E, through edge E+WIDTH.
  - After edge E+WIDTH: `busy`=0, `done`=1, `diff`/`borrow` valid.
  - After edge E+WIDTH+1: `done`=0, state IDLE.
  - Latency from accepted start to `done` is WIDTH+1 edges. Throughput is one operation per WIDTH+2 cycles minimum.
- `busy` and `done` are never high together. Both are registered outputs.
- Back-to-back: `start` held high continuously is accepted on the first IDLE cycle after each DONE.

## Configuration
- `SERIAL_SUB_OVF_EN`:
  - **Defined:** port `ovf` exists.
    - On the last SHIFT step, `ovf` is registered as `(ra_msb_orig != rb_msb_orig) && (d != ra_msb_orig)`, i.e. signed overflow of `a - b`.
    - The original operand MSBs are held in dedicated flops at capture.
    - `ovf` is valid and held with `diff`, and is reset to 0.
  - **Undefined:** no `ovf` port and no associated flops. All other behaviour is identical.

## Test plan
- **Basic subtract:** WIDTH=8; `a`=5, `b`=3, `start` for 1 cycle → `busy` for 8 cycles; `done` high on the 9th edge with `diff`=8'h02, `borrow`=0.
- **Underflow:** `a`=3, `b`=5 → `diff`=8'hFE, `borrow`=1. Also `a`=0, `b`=0 → `diff`=0, `borrow`=0. Also `a`=8'hFF, `b`=8'hFF → `diff`=0, `borrow`=0.
- **Overflow (macro defined):**
  - `a`=8'h80, `b`=8'h01 → `diff`=8'h7F, `borrow`=0, `ovf`=1.
  - `a`=8'h7F, `b`=8'hFF → `diff`=8'h80, `borrow`=1, `ovf`=1.
  - `a`=8'h10, `b`=8'h01 → `ovf`=0.
- **Ignored start and input change:** pulse `start` again at SHIFT cycle 3 with different operands, and change `a`/`b` mid-operation → exactly one `done`, result of the original operands; next IDLE without `start` stays IDLE.
- **Reset mid-operation:** drop `rst_n` at SHIFT cycle 4 → all outputs 0 immediately, no `done`; a new `start` after release completes correctly.
- **Exhaustive sweep:** WIDTH=4; all 256 `{a,b}` pairs back-to-back with `start` held high → each `diff == (a-b)&4'hF` and `borrow == (a<b)`; `$monitor` logs time, `a`, `b`, `diff`, `borrow`; VCD dumped.
